// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Optional overflow output is controlled by SERIAL_ADDSUB_OVF_EN.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of serial_addsub; out_ovf exists only with SERIAL_ADDSUB_OVF_EN.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             in_start;
   logic             in_mode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_busy;
   logic             out_done;
   logic [WIDTH-1:0] out_s;
   logic             out_co;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             out_ovf;
`endif

   modport master (
`ifdef SERIAL_ADDSUB_OVF_EN
      input  out_ovf,
`endif
      output in_start, in_mode, in_a, in_b,
      input  out_busy, out_done, out_s, out_co
   );

   modport slave (
`ifdef SERIAL_ADDSUB_OVF_EN
      output out_ovf,
`endif
      input  in_start, in_mode, in_a, in_b,
      output out_busy, out_done, out_s, out_co
   );

endinterface

// File: rtl/serial_addsub_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock through fa_cell.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_addsub_if.slave bus
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_r, state_nx_s;
   logic             accept_s, last_s;
   logic [WIDTH-1:0] opa_r, opb_r, acc_r, acc_nx_s, s_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r, co_r, busy_r, done_r;
   logic             fa_s_s, fa_co_s;
`ifdef SERIAL_ADDSUB_OVF_EN
   logic             ovf_r;
`endif

   fa_cell u_fa (
      .a  (opa_r[0]),
      .b  (opb_r[0]),
      .ci (carry_r),
      .s  (fa_s_s),
      .co (fa_co_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode; DONE doubles as an acceptance slot for back-to-back use
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_start) begin
               state_nx_s = ST_RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == LAST) begin
               state_nx_s = ST_DONE;
               last_s     = 1'b1;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.in_start) begin
               state_nx_s = ST_RUN;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Accumulator with this cycle's sum bit entering at the MSB
   always_comb begin
      acc_nx_s            = acc_r >> 1;
      acc_nx_s[WIDTH-1]   = fa_s_s;
   end

   // Operand shifters, carry chain, counter and accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_r   <= '0;
         opb_r   <= '0;
         acc_r   <= '0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
      end else if (accept_s) begin
         // Subtraction is a + ~b + 1: invert B and seed the carry with the mode bit
         opa_r   <= bus.in_a;
         opb_r   <= bus.in_b ^ {WIDTH{bus.in_mode == MODE_SUB}};
         carry_r <= bus.in_mode;
         acc_r   <= '0;
         cnt_r   <= '0;
      end else if (state_r == ST_RUN) begin
         opa_r   <= opa_r >> 1;
         opb_r   <= opb_r >> 1;
         carry_r <= fa_co_s;
         acc_r   <= acc_nx_s;
         cnt_r   <= cnt_r + CW'(1);
      end
   end

   // Result and status registers; results only change on the final bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r    <= '0;
         co_r   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == ST_RUN);
         done_r <= (state_nx_s == ST_DONE);
         if (last_s) begin
            s_r  <= acc_nx_s;
            co_r <= fa_co_s;
         end
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   // On the last bit carry_r is the carry into the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (last_s) begin
         ovf_r <= carry_r ^ fa_co_s;
      end
   end

   assign bus.out_ovf = ovf_r;
`endif

   assign bus.out_busy = busy_r;
   assign bus.out_done = done_r;
   assign bus.out_s    = s_r;
   assign bus.out_co   = co_r;

endmodule
